// File: rtl/match_event_logger.sv
// match_event_logger: timestamps rising edges of a detector's match output
// and queues the timestamps in a small first-word-fall-through FIFO.
// It also keeps a saturating event count and a sticky overflow flag.
//
// Read handshake (valid/ready style): rd_valid is high whenever the FIFO holds
// data, and rd_data then shows the oldest entry. A pop happens on a rising
// edge where rd_en and rd_valid are both high. rd_en while rd_valid is low is
// ignored. rd_data holds steady while rd_valid is high and no pop occurs.
module match_event_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             enable,
  input  logic             match,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [TS_W-1:0]  rd_data,
  output logic             full,
  output logic             overflow,
  output logic [CNT_W-1:0] match_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

  logic [TS_W-1:0]  ts;
  logic             match_d;
  logic [TS_W-1:0]  mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt;

  logic ev;
  logic pop;
  logic push;
  logic drop;

  // Event and FIFO control; clr suppresses every event, push and pop.
  always_comb begin
    ev   = match & ~match_d & enable & ~clr;
    pop  = rd_en & (occ != '0) & ~clr;
    push = ev & ((occ != OCC_FULL) | pop);
    drop = ev & (occ == OCC_FULL) & ~pop;
  end

  // Free-running timestamp and match edge history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts      <= '0;
      match_d <= 1'b0;
    end else if (clr) begin
      ts      <= '0;
      match_d <= 1'b0;
    end else begin
      match_d <= match;
      if (enable) ts <= ts + TS_W'(1);
    end
  end

  // FIFO storage; contents need no reset because occ gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ts;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Sticky overflow and saturating event counter (counts dropped events too).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      cnt   <= '0;
    end else if (clr) begin
      ovf_q <= 1'b0;
      cnt   <= '0;
    end else begin
      if (drop) ovf_q <= 1'b1;
      if (ev && (cnt != '1)) cnt <= cnt + CNT_W'(1);
    end
  end

  assign rd_valid    = (occ != '0);
  assign full        = (occ == OCC_FULL);
  assign rd_data     = rd_valid ? mem[rd_ptr] : '0;
  assign overflow    = ovf_q;
  assign match_count = cnt;

endmodule
